// File: rtl/booth_mult_pkg.sv
// Shared widths and encodings for the radix-4 Booth 8x8 unsigned multiplier.
package booth_mult_pkg;

    localparam int OPW     = 8;
    localparam int EXTW    = 10;
    localparam int MDW     = 11;
    localparam int ACCW    = 18;
    localparam int PRODW   = 16;
    localparam int NDIGITS = 5;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'b00,
        SEL_1X   = 2'b01,
        SEL_2X   = 2'b10,
        SEL_RSVD = 2'b11
    } sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 modified Booth recoder: triplet {b[2i+1], b[2i], b[2i-1]} -> multiple select and subtract flag.
module booth_r4_recoder
    import booth_mult_pkg::*;
(
    input  logic [2:0] triplet,
    output sel_e       sel,
    output logic       sub
);

    always_comb begin
        sel = SEL_ZERO;
        sub = 1'b0;
        case (triplet)
            3'b001, 3'b010: sel = SEL_1X;
            3'b011:         sel = SEL_2X;
            3'b100: begin
                sel = SEL_2X;
                sub = 1'b1;
            end
            3'b101, 3'b110: begin
                sel = SEL_1X;
                sub = 1'b1;
            end
            default: begin
                sel = SEL_ZERO;
                sub = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_r4_mult8_us.sv
// Sequential 8x8 unsigned radix-4 Booth multiplier, one digit per clock, product 5 cycles after load.
// Optional MULT_DONE_EN adds a one-cycle done pulse when prod updates.
//
// state   | meaning
// ST_IDLE | waiting for load, prod holds last result
// ST_RUN  | accumulating digits; cnt counts down 4..0, cnt==0 is the last digit
module booth_r4_mult8_us
    import booth_mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic [PRODW-1:0] prod
`ifdef MULT_DONE_EN
    ,
    output logic             done
`endif
);

    localparam logic [2:0] LAST_CNT = 3'(NDIGITS - 1);

    state_e                  state_q, state_d;
    logic [EXTW-1:0]         ad_q;
    logic [EXTW-1:0]         bd_sr;
    logic                    bd_prev;
    logic [2:0]              cnt;
    logic [2:0]              digit_idx;
    logic signed [ACCW-1:0]  acc;
    logic signed [ACCW-1:0]  acc_next;
    logic signed [ACCW-1:0]  mult_ext;
    logic signed [ACCW-1:0]  weighted;
    logic [MDW-1:0]          mult;
    sel_e                    sel;
    logic                    sub;
    logic                    last_digit;

    booth_r4_recoder u_recoder (
        .triplet ({bd_sr[1:0], bd_prev}),
        .sel     (sel),
        .sub     (sub)
    );

    always_comb begin
        mult = '0;
        case (sel)
            SEL_1X:  mult = {ad_q[EXTW-1], ad_q};
            SEL_2X:  mult = {ad_q, 1'b0};
            default: mult = '0;
        endcase
    end

    // Multiple is weighted by 4^i in place rather than shifting the accumulator.
    always_comb begin
        digit_idx = LAST_CNT - cnt;
        mult_ext  = {{(ACCW-MDW){mult[MDW-1]}}, mult};
        weighted  = mult_ext << {digit_idx, 1'b0};
        acc_next  = sub ? (acc - weighted) : (acc + weighted);
    end

    assign last_digit = (state_q == ST_RUN) && (cnt == 3'd0) && !load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load) state_d = ST_RUN;
            ST_RUN: begin
                if (load)              state_d = ST_RUN;
                else if (cnt == 3'd0)  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ad_q    <= '0;
            bd_sr   <= '0;
            bd_prev <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            prod    <= '0;
        end else if (load) begin
            ad_q    <= {2'b00, a};
            bd_sr   <= {2'b00, b};
            bd_prev <= 1'b0;
            cnt     <= LAST_CNT;
            acc     <= '0;
        end else if (state_q == ST_RUN) begin
            acc     <= acc_next;
            bd_sr   <= {2'b00, bd_sr[EXTW-1:2]};
            bd_prev <= bd_sr[1];
            if (cnt != 3'd0) cnt <= cnt - 3'd1;
            if (last_digit)  prod <= acc_next[PRODW-1:0];
        end
    end

`ifdef MULT_DONE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) done <= 1'b0;
        else      done <= last_digit;
    end
`endif

endmodule

// File: tb/tb_booth_r4_mult8_us.sv
// Self-checking bench for booth_r4_mult8_us: vector table, corner sequences and a random sweep vs a*b.
module tb_booth_r4_mult8_us;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [15:0] prod;
`ifdef MULT_DONE_EN
    logic        done;
`endif

    booth_r4_mult8_us dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .a    (a),
        .b    (b),
        .prod (prod)
`ifdef MULT_DONE_EN
        ,
        .done (done)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned p;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int unsigned last_prod = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_load(input int unsigned av, input int unsigned bv);
        @(negedge clk);
        load = 1'b1;
        a    = av[7:0];
        b    = bv[7:0];
        @(negedge clk);
        load = 1'b0;
    endtask

    // Called at the negedge right after the last load edge.
    task automatic wait_result(input string name, input int unsigned exp);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk({name, "_hold"}, prod, last_prod);
`ifdef MULT_DONE_EN
            chk({name, "_done_early"}, done, 0);
`endif
        end
        @(negedge clk);
        chk(name, prod, exp);
`ifdef MULT_DONE_EN
        chk({name, "_done"}, done, 1);
`endif
        last_prod = exp;
        @(negedge clk);
        chk({name, "_stable"}, prod, exp);
`ifdef MULT_DONE_EN
        chk({name, "_done_once"}, done, 0);
`endif
    endtask

    initial begin
        vec_t        vecs[$];
        int          done_cnt;
        int unsigned ra, rb;

        vecs.push_back('{255, 230, 58650});
        vecs.push_back('{5,   9,   45});
        vecs.push_back('{150, 100, 15000});
        vecs.push_back('{200, 250, 50000});
        vecs.push_back('{233, 111, 25863});
        vecs.push_back('{55,  46,  2530});
        vecs.push_back('{255, 255, 65025});
        vecs.push_back('{0,   200, 0});
        vecs.push_back('{200, 0,   0});
        vecs.push_back('{1,   1,   1});
        vecs.push_back('{128, 2,   256});

        repeat (3) @(negedge clk);
        chk("reset_prod", prod, 0);
`ifdef MULT_DONE_EN
        chk("reset_done", done, 0);
`endif
        rst = 1'b1;

        foreach (vecs[i]) begin
            do_load(vecs[i].a, vecs[i].b);
            wait_result($sformatf("vec%0d", i), vecs[i].p);
        end

        // Restart two cycles after the first load.
        do_load(13, 15);
        @(negedge clk);
        do_load(7, 9);
        done_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("restart_no_stale", (prod == 16'd195) ? 1 : 0, 0);
`ifdef MULT_DONE_EN
            if (done) done_cnt++;
`endif
            if (k < 5) chk("restart_hold", prod, last_prod);
            if (k == 5) chk("restart_prod", prod, 63);
        end
        last_prod = 63;
`ifdef MULT_DONE_EN
        chk("restart_done_count", done_cnt, 1);
`endif

        // Load held over several edges: only the last sampled operands count.
        @(negedge clk);
        load = 1'b1; a = 8'd3;  b = 8'd4;
        @(negedge clk);
        a = 8'd10; b = 8'd20;
        @(negedge clk);
        a = 8'd11; b = 8'd12;
        @(negedge clk);
        load = 1'b0;
        wait_result("held_load", 132);

        // Async reset in the middle of an operation.
        do_load(100, 100);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midreset_prod", prod, 0);
`ifdef MULT_DONE_EN
        chk("midreset_done", done, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        last_prod = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_reset_idle", prod, 0);
`ifdef MULT_DONE_EN
            chk("post_reset_done", done, 0);
`endif
        end

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom_range(255, 0);
            rb = $urandom_range(255, 0);
            do_load(ra, rb);
            wait_result($sformatf("rand_%0dx%0d", ra, rb), ra * rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
